// File: rtl/dkong_snd_rom_arb.sv
// Shares one byte-wide ROM read port between the 8035 program fetch and the WAV sample fetcher.
// Each requester keeps a tagged one-byte cache; a tag miss raises a fetch, CPU wins unless WAV has waited too long.
module dkong_snd_rom_arb #(
  parameter logic [19:0] CPU_BASE     = 20'h00000,
  parameter logic [19:0] WAV_BASE     = 20'h80000,
  parameter int          WAV_MAX_WAIT = 64
)(
  input  logic        W_CLK_24576M,
  input  logic        W_RESETn,
  input  logic [11:0] I_CPU_A,
  output logic [7:0]  O_CPU_D,
  output logic        O_CPU_VALID,
  input  logic [18:0] I_WAV_A,
  output logic [7:0]  O_WAV_D,
  output logic        O_WAV_VALID,
  output logic [19:0] O_MEM_A,
  output logic        O_MEM_RD,
  input  logic [7:0]  I_MEM_D,
  input  logic        I_MEM_ACK
);

  typedef enum logic {IDLE, REQ} state_t;
  typedef struct packed {
    logic        wav;
    logic [18:0] addr;
  } req_t;

  localparam logic [6:0] MAX_WAIT = 7'(WAV_MAX_WAIT);

  state_t      state;
  req_t        req;
  logic [11:0] cpu_tag;
  logic        cpu_tv;
  logic [18:0] wav_tag;
  logic        wav_tv;
  logic [6:0]  wait_cnt;
  logic        cpu_pend, wav_pend, grant_wav, serving_wav;

  assign O_CPU_VALID = cpu_tv && (I_CPU_A == cpu_tag);
  assign O_WAV_VALID = wav_tv && (I_WAV_A == wav_tag);
  assign cpu_pend    = !O_CPU_VALID;
  assign wav_pend    = !O_WAV_VALID;
  assign grant_wav   = wav_pend && (wait_cnt >= MAX_WAIT || !cpu_pend);
  assign serving_wav = (state == REQ) && req.wav;

  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      state    <= IDLE;
      req      <= '0;
      O_MEM_A  <= '0;
      O_MEM_RD <= 1'b0;
      O_CPU_D  <= '0;
      O_WAV_D  <= '0;
      cpu_tag  <= '0;
      cpu_tv   <= 1'b0;
      wav_tag  <= '0;
      wav_tv   <= 1'b0;
    end else if (state == IDLE) begin
      if (cpu_pend || wav_pend) begin
        state    <= REQ;
        O_MEM_RD <= 1'b1;
        req.wav  <= grant_wav;
        req.addr <= grant_wav ? I_WAV_A : {7'b0, I_CPU_A};
        O_MEM_A  <= grant_wav ? WAV_BASE + {1'b0, I_WAV_A} : CPU_BASE + {8'b0, I_CPU_A};
      end
    end else if (I_MEM_ACK) begin
      // Tag takes the issued address, so a requester that moved on during REQ stays pending.
      state    <= IDLE;
      O_MEM_RD <= 1'b0;
      if (req.wav) begin
        O_WAV_D <= I_MEM_D;
        wav_tag <= req.addr;
        wav_tv  <= 1'b1;
      end else begin
        O_CPU_D <= I_MEM_D;
        cpu_tag <= req.addr[11:0];
        cpu_tv  <= 1'b1;
      end
    end
  end

  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn)
      wait_cnt <= '0;
    else if (!wav_pend || (state == IDLE && grant_wav))
      wait_cnt <= '0;
    else if (!serving_wav && wait_cnt != 7'h7f)
      wait_cnt <= wait_cnt + 7'd1;
  end

endmodule

// File: tb/tb_dkong_snd_rom_arb.sv
// Bench for dkong_snd_rom_arb: memory model with programmable ack latency, queue of expected
// read addresses checked by a monitor on every RD rise, plus directed data/valid checks.
module tb_dkong_snd_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_valid;
  logic [18:0] wav_a;
  logic [7:0]  wav_d;
  logic        wav_valid;
  logic [19:0] mem_a;
  logic        mem_rd;
  logic [7:0]  mem_d;
  logic        mem_ack;

  dkong_snd_rom_arb dut (
    .W_CLK_24576M(clk), .W_RESETn(rst_n),
    .I_CPU_A(cpu_a), .O_CPU_D(cpu_d), .O_CPU_VALID(cpu_valid),
    .I_WAV_A(wav_a), .O_WAV_D(wav_d), .O_WAV_VALID(wav_valid),
    .O_MEM_A(mem_a), .O_MEM_RD(mem_rd), .I_MEM_D(mem_d), .I_MEM_ACK(mem_ack)
  );

  always #10 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  int mem_lat = 1;
  bit stray_en = 0;
  bit sb_on = 1;
  logic [19:0] watch_addr = '1;
  int seen_cyc = -1;
  logic [19:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Memory: ROM byte = low address byte ^ A5, acked mem_lat cycles after RD is seen.
  initial begin
    int wcnt;
    bit busy;
    busy = 0; wcnt = 0;
    mem_ack = 1'b0; mem_d = 8'h00;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (rst_n && mem_rd) begin
        if (!busy) begin busy = 1; wcnt = 0; end
        else wcnt++;
        if (wcnt == mem_lat - 1) begin
          mem_ack = 1'b1;
          mem_d   = mem_a[7:0] ^ 8'hA5;
          busy    = 0;
        end
      end else begin
        busy = 0;
        if (stray_en) begin mem_ack = 1'b1; mem_d = 8'hFF; end
      end
    end
  end

  // Monitor: every new read request is compared against the next expected address.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_rd && !prev) begin
        if (mem_a == watch_addr && seen_cyc < 0) seen_cyc = cyc;
        if (sb_on) begin
          if (exp_q.size() == 0) chk("unexpected_rd", {12'h0, mem_a}, 32'hFFFFFFFF);
          else chk("rd_addr", {12'h0, mem_a}, {12'h0, exp_q.pop_front()});
        end
      end
      prev = mem_rd;
    end
  end

  task automatic wait_both_valid(input string name);
    int n;
    n = 0;
    while (!(cpu_valid && wav_valid && !mem_rd) && n < 300) begin tick(); n++; end
    chk(name, {31'h0, cpu_valid && wav_valid}, 32'h1);
  endtask

  initial begin
    int start;
    rst_n = 1'b0;
    cpu_a = 12'h005;
    wav_a = 19'h00010;
    repeat (3) tick();
    chk("rst_rd",   {31'h0, mem_rd},    32'h0);
    chk("rst_a",    {12'h0, mem_a},     32'h0);
    chk("rst_cpud", {24'h0, cpu_d},     32'h0);
    chk("rst_wavd", {24'h0, wav_d},     32'h0);
    chk("rst_vld",  {30'h0, cpu_valid, wav_valid}, 32'h0);

    // Basic fetch, then CPU-first arbitration with a one-cycle gap before WAV.
    exp_q.push_back(20'h00005);
    exp_q.push_back(20'h80010);
    rst_n = 1'b1;
    tick();
    chk("t1_rd_hi",   {31'h0, mem_rd},    32'h1);
    chk("t1_cpu_v0",  {31'h0, cpu_valid}, 32'h0);
    tick();
    chk("t1_rd_lo",   {31'h0, mem_rd},    32'h0);
    chk("t1_cpu_v1",  {31'h0, cpu_valid}, 32'h1);
    chk("t1_cpu_d",   {24'h0, cpu_d},     32'hA0);
    tick();
    chk("t2_rd_wav",  {31'h0, mem_rd},    32'h1);
    chk("t2_wav_v0",  {31'h0, wav_valid}, 32'h0);
    tick();
    chk("t2_wav_v1",  {31'h0, wav_valid}, 32'h1);
    chk("t2_wav_d",   {24'h0, wav_d},     32'hB5);
    chk("t2_cpu_v",   {31'h0, cpu_valid}, 32'h1);

    // Stray acks while idle must not disturb anything.
    stray_en = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_rd_lo", {31'h0, mem_rd}, 32'h0);
    end
    stray_en = 0;
    tick();
    chk("t6_vld",  {30'h0, cpu_valid, wav_valid}, 32'h3);
    chk("t6_cpud", {24'h0, cpu_d}, 32'hA0);
    chk("t6_wavd", {24'h0, wav_d}, 32'hB5);

    // Address change during REQ: old byte stored, VALID stays low, refetch of new address.
    mem_lat = 2;
    exp_q.push_back(20'h00010);
    exp_q.push_back(20'h00011);
    cpu_a = 12'h010;
    tick();
    chk("t4_rd_hi", {31'h0, mem_rd}, 32'h1);
    cpu_a = 12'h011;
    tick();
    chk("t4_rd_hold", {31'h0, mem_rd},    32'h1);
    chk("t4_v_mid",   {31'h0, cpu_valid}, 32'h0);
    tick();
    chk("t4_rd_lo",   {31'h0, mem_rd},    32'h0);
    chk("t4_v_stale", {31'h0, cpu_valid}, 32'h0);
    chk("t4_d_old",   {24'h0, cpu_d},     32'hB5);
    tick();
    chk("t4_rd_re",   {31'h0, mem_rd},    32'h1);
    tick(); tick();
    chk("t4_v_new",   {31'h0, cpu_valid}, 32'h1);
    chk("t4_d_new",   {24'h0, cpu_d},     32'hB4);

    // Anti-starvation: CPU address changes every cycle, so CPU is always pending.
    sb_on = 0;
    watch_addr = 20'h80123;
    seen_cyc = -1;
    wav_a = 19'h00123;
    start = cyc;
    for (int i = 0; i < 100 && seen_cyc < 0; i++) begin
      cpu_a = cpu_a + 12'h001;
      tick();
    end
    chk("t3_starve_seen", {31'h0, seen_cyc >= 0}, 32'h1);
    chk("t3_not_early",   {31'h0, (seen_cyc - start) >= 64}, 32'h1);
    chk("t3_bound",       {31'h0, (seen_cyc - start) <= 68}, 32'h1);

    // CPU address changing every 4 cycles.
    wait_both_valid("t3_settle1");
    watch_addr = 20'h80124;
    seen_cyc = -1;
    wav_a = 19'h00124;
    start = cyc;
    for (int i = 0; i < 100 && seen_cyc < 0; i++) begin
      if (i % 4 == 0) cpu_a = cpu_a + 12'h001;
      tick();
    end
    chk("t3_bound4", {31'h0, seen_cyc >= 0 && (seen_cyc - start) <= 68}, 32'h1);
    wait_both_valid("t3_settle2");
    sb_on = 1;

    // Reset in the middle of a CPU fetch.
    cpu_a = 12'h020;
    exp_q.push_back(20'h00020);
    tick();
    chk("t5_rd_hi", {31'h0, mem_rd}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_rd_lo", {31'h0, mem_rd}, 32'h0);
    chk("t5_vld",   {30'h0, cpu_valid, wav_valid}, 32'h0);
    chk("t5_a",     {12'h0, mem_a}, 32'h0);
    tick(); tick();
    exp_q.push_back(20'h00020);
    exp_q.push_back(20'h80124);
    rst_n = 1'b1;
    wait_both_valid("t5_refetch");
    chk("t5_cpud", {24'h0, cpu_d}, 32'h85);
    chk("t5_wavd", {24'h0, wav_d}, 32'h81);

    tick(); tick();
    chk("sb_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
